// File: rtl/fsb_pkg.sv
// Shared types and defaults for the 68000 front-side bus cycle controller.
package fsb_pkg;
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_TERM = 2'd2,
        S_HOLD = 2'd3
    } fsb_state_e;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd1;
    localparam logic [1:0] ERR_CONFLICT = 2'd2;

    localparam int NCH_DEF    = 4;
    localparam int TO_CYC_DEF = 64;
endpackage

// File: rtl/fsb_tocnt.sv
// Saturating wait-state counter; tc flags the last cycle before a bus-error timeout.
module fsb_tocnt
    import fsb_pkg::*;
#(
    parameter int TO_CYC = TO_CYC_DEF
) (
    input  logic FCLK,
    input  logic RST,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam int CW = $clog2(TO_CYC + 1);
    localparam logic [CW-1:0] LAST = CW'(TO_CYC - 1);
    localparam logic [CW-1:0] SAT  = CW'(TO_CYC);

    logic [CW-1:0] cnt;

    always_ff @(posedge FCLK) begin
        if (RST || clr) begin
            cnt <= '0;
        end else if (en && (cnt != SAT)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = (cnt == LAST);
endmodule

// File: rtl/fsb_ctl.sv
// 68000 bus cycle terminator: picks nDTACK, nVPA or nBERR for each address-strobe cycle.
module fsb_ctl
    import fsb_pkg::*;
#(
    parameter int              NCH      = NCH_DEF,
    parameter logic [NCH-1:0]  VPA_MASK = '0,
    parameter int              TO_CYC   = TO_CYC_DEF
) (
    input  logic           FCLK,
    input  logic           RST,
    input  logic           nAS,
    input  logic [NCH-1:0] CS,
    input  logic [NCH-1:0] RDY,
    input  logic           IACS,
    output logic           nDTACK,
    output logic           nVPA,
    output logic           nBERR,
    output logic           BACT,
    output logic [1:0]     ERR,
    output fsb_state_e     dbg_state
);
    // Handshake: a cycle opens when nAS is seen low while armed; exactly one strobe
    // answers it and is held until nAS is seen high, which closes the cycle.
    fsb_state_e state;
    logic       asr;
    logic       armed;
    logic       multi_cs;
    logic       ready;
    logic       vpa_sel;
    logic       tc;
    logic       cnt_clr;
    logic       cnt_en;

    always_comb begin
        multi_cs = ((CS & (CS - NCH'(1))) != '0);
        ready    = IACS || ((CS & RDY) != '0);
        vpa_sel  = IACS || ((CS & VPA_MASK) != '0);
        cnt_clr  = ((state == S_IDLE) && !nAS && armed) || ((state == S_WAIT) && nAS);
        cnt_en   = (state == S_WAIT) && !ready;
    end

    fsb_tocnt #(.TO_CYC(TO_CYC)) u_tocnt (
        .FCLK (FCLK),
        .RST  (RST),
        .clr  (cnt_clr),
        .en   (cnt_en),
        .tc   (tc)
    );

    always_ff @(posedge FCLK) begin
        if (RST) begin
            state  <= S_IDLE;
            nDTACK <= 1'b1;
            nVPA   <= 1'b1;
            nBERR  <= 1'b1;
            asr    <= 1'b0;
            ERR    <= ERR_NONE;
            armed  <= 1'b0;
        end else begin
            asr <= !nAS;
            if (nAS) begin
                armed <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (!nAS && armed) begin
                        state <= S_WAIT;
                        armed <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (nAS) begin
                        state <= S_IDLE;
                    end else if (multi_cs && !IACS) begin
                        nBERR <= 1'b0;
                        ERR   <= ERR_CONFLICT;
                        state <= S_TERM;
                    end else if (ready) begin
                        if (vpa_sel) nVPA <= 1'b0;
                        else         nDTACK <= 1'b0;
                        state <= S_TERM;
                    end else if (tc) begin
                        nBERR <= 1'b0;
                        ERR   <= ERR_TIMEOUT;
                        state <= S_TERM;
                    end
                end
                S_TERM: begin
                    // A low nAS with ASr clear means the high phase slipped between samples.
                    if (nAS || !asr) begin
                        nDTACK <= 1'b1;
                        nVPA   <= 1'b1;
                        nBERR  <= 1'b1;
                        state  <= nAS ? S_IDLE : S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (nAS) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign BACT      = !nAS || asr;
    assign dbg_state = state;
endmodule

// File: tb/tb_fsb_ctl.sv
// Randomized and directed bench for fsb_ctl against a per-transaction outcome model.
module tb_fsb_ctl;
    import fsb_pkg::*;

    localparam int             NCH      = 4;
    localparam logic [NCH-1:0] VPA_MASK = 4'b0100;
    localparam int             TO_CYC   = 8;

    // Strobe triples are {nDTACK, nVPA, nBERR}.
    localparam logic [2:0] ST_NONE = 3'b111;
    localparam logic [2:0] ST_DT   = 3'b011;
    localparam logic [2:0] ST_VP   = 3'b101;
    localparam logic [2:0] ST_BE   = 3'b110;

    logic           FCLK = 1'b0;
    logic           RST  = 1'b1;
    logic           nAS  = 1'b1;
    logic [NCH-1:0] CS   = '0;
    logic [NCH-1:0] RDY  = '0;
    logic           IACS = 1'b0;
    logic           nDTACK, nVPA, nBERR, BACT;
    logic [1:0]     ERR;
    fsb_state_e     dbg_state;

    int         n_vec = 0;
    int         n_err = 0;
    logic [1:0] err_m = 2'd0;
    logic [2:0] exp_q[$];

    fsb_ctl #(.NCH(NCH), .VPA_MASK(VPA_MASK), .TO_CYC(TO_CYC)) dut (
        .FCLK      (FCLK),
        .RST       (RST),
        .nAS       (nAS),
        .CS        (CS),
        .RDY       (RDY),
        .IACS      (IACS),
        .nDTACK    (nDTACK),
        .nVPA      (nVPA),
        .nBERR     (nBERR),
        .BACT      (BACT),
        .ERR       (ERR),
        .dbg_state (dbg_state)
    );

    always #5 FCLK = ~FCLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge FCLK);
        #1;
    endtask

    // One complete bus cycle: the expected outcome comes from the rules, then each
    // edge's strobes are checked against the queued expectation.
    task automatic run_txn(input logic [NCH-1:0] cs, input logic iacs,
                           input logic [NCH-1:0] rdy_mask, input int rdy_edge,
                           input int hold, input string name);
        int         out_edge;
        logic [2:0] kind;
        logic [2:0] exp;
        logic [2:0] got;
        if (!iacs && $countones(cs) >= 2) begin
            out_edge = 1; kind = ST_BE; err_m = ERR_CONFLICT;
        end else if (iacs) begin
            out_edge = 1; kind = ST_VP;
        end else if ($countones(cs) == 1 && (cs & rdy_mask) != 0 && rdy_edge <= TO_CYC) begin
            out_edge = rdy_edge;
            kind = ((cs & VPA_MASK) != 0) ? ST_VP : ST_DT;
        end else begin
            out_edge = TO_CYC; kind = ST_BE; err_m = ERR_TIMEOUT;
        end
        exp_q.push_back(ST_NONE);
        for (int k = 1; k <= out_edge + hold; k++) exp_q.push_back((k >= out_edge) ? kind : ST_NONE);
        exp_q.push_back(ST_NONE);

        nAS = 1'b0; CS = cs; IACS = iacs; RDY = '0;
        for (int k = 0; k <= out_edge + hold; k++) begin
            if (k > 0) RDY = (k >= rdy_edge) ? rdy_mask : '0;
            tick();
            exp = exp_q.pop_front();
            got = {nDTACK, nVPA, nBERR};
            n_vec++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL %s edge %0d strobes: got %b want %b", name, k, got, exp);
            end
        end
        nAS = 1'b1; CS = '0; IACS = 1'b0; RDY = '0;
        #2;
        n_vec++;
        if (BACT !== 1'b1) begin
            n_err++;
            $display("FAIL %s bact_trail: got %b want 1", name, BACT);
        end
        tick();
        exp = exp_q.pop_front();
        got = {nDTACK, nVPA, nBERR};
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s release strobes: got %b want %b", name, got, exp);
        end
        n_vec++;
        if (BACT !== 1'b0) begin
            n_err++;
            $display("FAIL %s bact_idle: got %b want 0", name, BACT);
        end
        n_vec++;
        if (ERR !== err_m) begin
            n_err++;
            $display("FAIL %s err: got %0d want %0d", name, ERR, err_m);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1; nAS = 1'b1;
        tick(); tick();
        err_m = ERR_NONE;
        n_vec++;
        if ({nDTACK, nVPA, nBERR} !== ST_NONE) begin
            n_err++;
            $display("FAIL reset strobes: got %b want %b", {nDTACK, nVPA, nBERR}, ST_NONE);
        end
        n_vec++;
        if (ERR !== 2'd0 || BACT !== 1'b0) begin
            n_err++;
            $display("FAIL reset err_bact: got %0d/%b want 0/0", ERR, BACT);
        end
        RST = 1'b0;
        tick();
    endtask

    task automatic test_dtack();
        run_txn(4'b0010, 1'b0, 4'b0010, 3, 2, "dtack");
    endtask

    task automatic test_vpa();
        run_txn(4'b0100, 1'b0, 4'b0100, 2, 1, "vpa_mask");
        run_txn(4'b0000, 1'b1, 4'b0000, 1, 1, "iack");
    endtask

    task automatic test_timeout();
        run_txn(4'b0001, 1'b0, 4'b0000, 99, 1, "timeout");
        run_txn(4'b0001, 1'b0, 4'b0001, TO_CYC, 1, "ready_wins");
        run_txn(4'b0000, 1'b0, 4'b1111, 1, 0, "no_select");
    endtask

    task automatic test_conflict();
        run_txn(4'b0011, 1'b0, 4'b0011, 1, 1, "conflict");
    endtask

    task automatic test_reset_mid_wait();
        nAS = 1'b0; CS = 4'b0001; RDY = '0;
        tick(); tick();
        RST = 1'b1;
        tick();
        err_m = ERR_NONE;
        RST = 1'b0; RDY = 4'b0001;
        for (int k = 0; k < 5; k++) begin
            n_vec++;
            if ({nDTACK, nVPA, nBERR} !== ST_NONE) begin
                n_err++;
                $display("FAIL rst_mid cycle %0d strobes: got %b want %b", k, {nDTACK, nVPA, nBERR}, ST_NONE);
            end
            tick();
        end
        n_vec++;
        if (ERR !== 2'd0) begin
            n_err++;
            $display("FAIL rst_mid err: got %0d want 0", ERR);
        end
        nAS = 1'b1; CS = '0; RDY = '0;
        tick();
        run_txn(4'b0001, 1'b0, 4'b0001, 2, 1, "after_rst");
    endtask

    task automatic test_abort();
        nAS = 1'b0; CS = 4'b0010; RDY = '0;
        for (int k = 0; k < 6; k++) begin
            tick();
            n_vec++;
            if ({nDTACK, nVPA, nBERR} !== ST_NONE) begin
                n_err++;
                $display("FAIL abort edge %0d strobes: got %b want %b", k, {nDTACK, nVPA, nBERR}, ST_NONE);
            end
        end
        nAS = 1'b1; CS = '0;
        tick();
        n_vec++;
        if ({nDTACK, nVPA, nBERR} !== ST_NONE) begin
            n_err++;
            $display("FAIL abort release strobes: got %b want %b", {nDTACK, nVPA, nBERR}, ST_NONE);
        end
        run_txn(4'b1000, 1'b0, 4'b0000, 99, 0, "abort_then_to");
        run_txn(4'b0010, 1'b0, 4'b0010, 1, 2, "abort_then_ack");
    endtask

    task automatic test_random();
        logic [NCH-1:0] cs;
        logic [NCH-1:0] rm;
        logic           iacs;
        int             sel;
        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 3);
            if (sel == 0)      cs = '0;
            else if (sel == 3) cs = NCH'($urandom_range(0, 15));
            else               cs = NCH'(1) << $urandom_range(0, NCH - 1);
            iacs = ($urandom_range(0, 5) == 0);
            rm   = ($urandom_range(0, 1) == 1) ? cs : NCH'($urandom_range(0, 15));
            run_txn(cs, iacs, rm, $urandom_range(1, 10), $urandom_range(0, 3), "random");
        end
    endtask

    initial begin
        test_reset();
        test_dtack();
        test_vpa();
        test_timeout();
        test_conflict();
        test_reset_mid_wait();
        test_abort();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
